// File: rtl/stu_context_copy_engine_if.sv
// Handshake bundle between the context copy engine, the fork controller and the register file.
// master = copy engine side, slave = controller / register-file side.
interface stu_context_copy_engine_if #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 64,
    parameter int CORE_ID_W = 2
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                 copy_start_in;
    logic [CORE_ID_W-1:0] src_core_id_in;
    logic [CORE_ID_W-1:0] dst_core_id_in;
    logic                 abort_in;

    logic                 rf_rd_req_out;
    logic [CORE_ID_W-1:0] rf_rd_core_out;
    logic [IDX_W-1:0]     rf_rd_idx_out;
    logic                 rf_rd_ack_in;
    logic [DATA_W-1:0]    rf_rd_data_in;

    logic                 rf_wr_req_out;
    logic [CORE_ID_W-1:0] rf_wr_core_out;
    logic [IDX_W-1:0]     rf_wr_idx_out;
    logic [DATA_W-1:0]    rf_wr_data_out;
    logic                 rf_wr_ack_in;

    logic                 copy_done_out;
    logic                 copy_error_out;
    logic                 busy_out;

    modport master (
        input  copy_start_in, src_core_id_in, dst_core_id_in, abort_in,
        input  rf_rd_ack_in, rf_rd_data_in, rf_wr_ack_in,
        output rf_rd_req_out, rf_rd_core_out, rf_rd_idx_out,
        output rf_wr_req_out, rf_wr_core_out, rf_wr_idx_out, rf_wr_data_out,
        output copy_done_out, copy_error_out, busy_out
    );

    modport slave (
        output copy_start_in, src_core_id_in, dst_core_id_in, abort_in,
        output rf_rd_ack_in, rf_rd_data_in, rf_wr_ack_in,
        input  rf_rd_req_out, rf_rd_core_out, rf_rd_idx_out,
        input  rf_wr_req_out, rf_wr_core_out, rf_wr_idx_out, rf_wr_data_out,
        input  copy_done_out, copy_error_out, busy_out
    );
endinterface

// File: rtl/stu_context_copy_engine.sv
// Copies the architectural register file of a master core into a speculative core, one read/write pair per register.
// Define STU_CTX_SKIP_X0_EN to skip register 0 (hard-wired zero) during the copy.
module stu_context_copy_engine #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 64,
    parameter int CORE_ID_W = 2
) (
    input logic                        clk,
    input logic                        rst,
    stu_context_copy_engine_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef STU_CTX_SKIP_X0_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [CORE_ID_W-1:0] src_q, dst_q;
    logic [DATA_W-1:0]    data_q;
    logic                 error_q;
    logic                 start_ok, start_bad;

    // An abort in IDLE suppresses both the copy and the same-id error.
    assign start_ok  = bus.copy_start_in && !bus.abort_in &&
                       (bus.src_core_id_in != bus.dst_core_id_in);
    assign start_bad = bus.copy_start_in && !bus.abort_in &&
                       (bus.src_core_id_in == bus.dst_core_id_in);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = RD;
            RD: begin
                if (bus.abort_in)          state_d = IDLE;
                else if (bus.rf_rd_ack_in) state_d = WR;
            end
            WR: begin
                if (bus.abort_in)          state_d = IDLE;
                else if (bus.rf_wr_ack_in) state_d = (idx_q == LAST_IDX) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        src_q <= bus.src_core_id_in;
                        dst_q <= bus.dst_core_id_in;
                        idx_q <= FIRST_IDX;
                    end else if (start_bad) begin
                        error_q <= 1'b1;
                    end
                end
                RD: if (!bus.abort_in && bus.rf_rd_ack_in) data_q <= bus.rf_rd_data_in;
                WR: begin
                    if (!bus.abort_in && bus.rf_wr_ack_in && idx_q != LAST_IDX)
                        idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_rd_req_out  = (state_q == RD);
    assign bus.rf_rd_core_out = src_q;
    assign bus.rf_rd_idx_out  = idx_q;
    assign bus.rf_wr_req_out  = (state_q == WR);
    assign bus.rf_wr_core_out = dst_q;
    assign bus.rf_wr_idx_out  = idx_q;
    assign bus.rf_wr_data_out = data_q;
    // Gated so an abort arriving in DONE never shows a completion.
    assign bus.copy_done_out  = (state_q == DONE) && !bus.abort_in;
    assign bus.copy_error_out = error_q;
    assign bus.busy_out       = (state_q != IDLE);
endmodule

// File: tb/tb_stu_context_copy_engine.sv
// Directed bench for stu_context_copy_engine: table of copy scenarios plus hand-written abort/reset sequences.
// Honours STU_CTX_SKIP_X0_EN for the expected first index and register count.
module tb_stu_context_copy_engine;
    localparam int NUM_REGS  = 32;
    localparam int DATA_W    = 64;
    localparam int CORE_ID_W = 2;
    localparam int IDX_W     = $clog2(NUM_REGS);
`ifdef STU_CTX_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int COUNT = NUM_REGS - FIRST;
    localparam int LAST  = NUM_REGS - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stu_context_copy_engine_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .CORE_ID_W(CORE_ID_W)) bus ();

    stu_context_copy_engine #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .CORE_ID_W(CORE_ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] src;
        logic [1:0] dst;
        int rd_stall_idx;
        int rd_stall;
        int wr_stall_idx;
        int wr_stall;
        int exp_done;
        int exp_err;
        int exp_count;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [1:0] core, input int idx);
        logic [23:0] mix;
        mix = 24'(idx * 7919 + 3);
        return {6'b0, core, 24'hC3A55A, mix, 8'(idx)};
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({bus.rf_rd_req_out, bus.rf_rd_core_out, bus.rf_rd_idx_out,
                     bus.rf_wr_req_out, bus.rf_wr_core_out, bus.rf_wr_idx_out, bus.rf_wr_data_out,
                     bus.copy_done_out, bus.copy_error_out, bus.busy_out});
    endfunction

    task automatic cyc();
        @(negedge clk);
        bus.copy_start_in = 1'b0;
        bus.abort_in      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.copy_start_in  = 1'b0;
        bus.abort_in       = 1'b0;
        bus.rf_rd_ack_in   = 1'b0;
        bus.rf_wr_ack_in   = 1'b0;
        bus.rf_rd_data_in  = '0;
        bus.src_core_id_in = '0;
        bus.dst_core_id_in = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic start_copy(input logic [1:0] s, input logic [1:0] d);
        bus.src_core_id_in = s;
        bus.dst_core_id_in = d;
        bus.copy_start_in  = 1'b1;
    endtask

    task automatic run_copy(input vec_t v, input string name);
        int done_cycle = -1;
        int ndone = 0, nerr = 0, reads = 0, writes = 0, viol = 0;
        int rd_wait = 0, wr_wait = 0, exp_idx = FIRST;
        bit want_wr = 0;
        do_reset();
        start_copy(v.src, v.dst);
        for (int c = 1; c <= 300; c++) begin
            cyc();
            bus.rf_rd_ack_in  = 1'b0;
            bus.rf_wr_ack_in  = 1'b0;
            bus.rf_rd_data_in = '1;
            if (bus.rf_rd_req_out && bus.rf_wr_req_out) viol++;
            if (bus.busy_out !== ((v.exp_done > 0) && (c <= v.exp_done))) viol++;
            if (bus.copy_error_out) nerr++;
            if (bus.copy_done_out) begin
                ndone++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (bus.rf_rd_req_out) begin
                if (want_wr || bus.rf_rd_core_out !== v.src || int'(bus.rf_rd_idx_out) != exp_idx) viol++;
                if (exp_idx == v.rd_stall_idx && rd_wait < v.rd_stall) rd_wait++;
                else begin
                    bus.rf_rd_ack_in  = 1'b1;
                    bus.rf_rd_data_in = pat(v.src, exp_idx);
                    reads++;
                    want_wr = 1;
                end
            end
            if (bus.rf_wr_req_out) begin
                if (!want_wr || bus.rf_wr_core_out !== v.dst || int'(bus.rf_wr_idx_out) != exp_idx ||
                    bus.rf_wr_data_out !== pat(v.src, exp_idx)) viol++;
                if (exp_idx == v.wr_stall_idx && wr_wait < v.wr_stall) wr_wait++;
                else begin
                    bus.rf_wr_ack_in = 1'b1;
                    writes++;
                    want_wr = 0;
                    exp_idx++;
                end
            end
            if ((v.exp_done < 0 && c >= 6) || (done_cycle >= 0 && c >= done_cycle + 2)) break;
        end
        bus.rf_rd_ack_in = 1'b0;
        bus.rf_wr_ack_in = 1'b0;
        check({name, " done_cycle"}, 128'(done_cycle), 128'(v.exp_done));
        check({name, " done_pulses"}, 128'(ndone), 128'((v.exp_done > 0) ? 1 : 0));
        check({name, " reads"}, 128'(reads), 128'(v.exp_count));
        check({name, " writes"}, 128'(writes), 128'(v.exp_count));
        check({name, " error_pulses"}, 128'(nerr), 128'(v.exp_err));
        check({name, " protocol_violations"}, 128'(viol), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int seen;
        vecs[0] = '{src: 2'd0, dst: 2'd2, rd_stall_idx: -1, rd_stall: 0, wr_stall_idx: -1, wr_stall: 0,
                    exp_done: 2*COUNT+1, exp_err: 0, exp_count: COUNT};
        vecs[1] = '{src: 2'd0, dst: 2'd2, rd_stall_idx: 5, rd_stall: 3, wr_stall_idx: 7, wr_stall: 2,
                    exp_done: 2*COUNT+1+5, exp_err: 0, exp_count: COUNT};
        vecs[2] = '{src: 2'd1, dst: 2'd1, rd_stall_idx: -1, rd_stall: 0, wr_stall_idx: -1, wr_stall: 0,
                    exp_done: -1, exp_err: 1, exp_count: 0};
        vecs[3] = '{src: 2'd3, dst: 2'd1, rd_stall_idx: LAST, rd_stall: 1, wr_stall_idx: FIRST, wr_stall: 4,
                    exp_done: 2*COUNT+1+5, exp_err: 0, exp_count: COUNT};
        vecs[4] = '{src: 2'd2, dst: 2'd0, rd_stall_idx: 16, rd_stall: 2, wr_stall_idx: 16, wr_stall: 2,
                    exp_done: 2*COUNT+1+4, exp_err: 0, exp_count: COUNT};

        bus.copy_start_in  = 1'b0;
        bus.abort_in       = 1'b0;
        bus.src_core_id_in = '0;
        bus.dst_core_id_in = '0;
        bus.rf_rd_ack_in   = 1'b0;
        bus.rf_wr_ack_in   = 1'b0;
        bus.rf_rd_data_in  = '0;

        do_reset();
        check("reset_outputs", all_outs(), '0);

        for (int i = 0; i < 5; i++) run_copy(vecs[i], $sformatf("vec%0d", i));

        // Abort at cycle 20, ignored same-id start while busy, restart at cycle 25.
        do_reset();
        bus.rf_rd_ack_in  = 1'b1;
        bus.rf_wr_ack_in  = 1'b1;
        bus.rf_rd_data_in = 64'h0123_4567_89AB_CDEF;
        start_copy(2'd0, 2'd2);
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (bus.copy_done_out) ndone++;
            if (c == 11) check("busy_start_ignored", 128'({bus.copy_error_out, bus.busy_out, bus.rf_rd_core_out}),
                               128'({1'b0, 1'b1, 2'd0}));
            if (c == 10) start_copy(2'd3, 2'd3);
            if (c == 20) bus.abort_in = 1'b1;
        end
        cyc();
        check("abort_next_cycle", 128'({bus.rf_rd_req_out, bus.rf_wr_req_out, bus.busy_out, bus.copy_done_out}), '0);
        for (int c = 22; c <= 25; c++) begin
            cyc();
            if (bus.copy_done_out) ndone++;
            if (c == 25) start_copy(2'd0, 2'd2);
        end
        check("abort_no_done", 128'(ndone), 128'(0));
        cyc();
        check("restart_first_idx", 128'({bus.rf_rd_req_out, bus.rf_rd_core_out, bus.rf_rd_idx_out, bus.busy_out}),
              128'({1'b1, 2'd0, IDX_W'(FIRST), 1'b1}));
        seen = -1;
        for (int c = 27; c <= 200; c++) begin
            cyc();
            if (bus.copy_done_out && seen < 0) seen = c;
            if (seen >= 0) break;
        end
        check("restart_done_cycle", 128'(seen), 128'(25 + 2*COUNT + 1));

        // Abort and start in the same IDLE cycle; also same-id start under abort.
        do_reset();
        start_copy(2'd0, 2'd2);
        bus.abort_in = 1'b1;
        cyc();
        check("idle_abort_start", 128'({bus.busy_out, bus.rf_rd_req_out, bus.copy_error_out}), '0);
        start_copy(2'd1, 2'd1);
        bus.abort_in = 1'b1;
        cyc();
        check("idle_abort_bad_start", 128'({bus.busy_out, bus.copy_error_out}), '0);

        // Abort coincident with the final write ack.
        do_reset();
        bus.rf_rd_ack_in = 1'b1;
        bus.rf_wr_ack_in = 1'b1;
        start_copy(2'd0, 2'd2);
        for (int c = 1; c <= 2*COUNT; c++) cyc();
        check("final_wr_phase", 128'({bus.rf_wr_req_out, bus.rf_wr_idx_out}), 128'({1'b1, IDX_W'(LAST)}));
        bus.abort_in = 1'b1;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (bus.copy_done_out || bus.busy_out) ndone++;
        end
        check("final_ack_abort", 128'(ndone), 128'(0));

        // Reset during WR with a start pulse in the same cycle.
        do_reset();
        bus.rf_rd_ack_in  = 1'b1;
        bus.rf_wr_ack_in  = 1'b1;
        bus.rf_rd_data_in = 64'hFEED_FACE_DEAD_BEEF;
        start_copy(2'd1, 2'd3);
        for (int c = 1; c <= 10; c++) cyc();
        check("pre_reset_in_wr", 128'({bus.rf_wr_req_out, bus.rf_wr_data_out}), 128'({1'b1, 64'hFEED_FACE_DEAD_BEEF}));
        rst = 1'b1;
        start_copy(2'd0, 2'd2);
        cyc();
        check("reset_mid_copy", all_outs(), '0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (bus.copy_done_out || bus.busy_out || bus.rf_rd_req_out) ndone++;
        end
        check("post_reset_idle", 128'(ndone), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stu_context_copy_engine.md
STU_CONTEXT_COPY_ENGINE -- requirements
Module: stu_context_copy_engine

Interface
REQ-001 SHALL have these parameters: NUM_REGS, 32, architectural registers copied per fork; DATA_W, 64, register width; CORE_ID_W, 2, core-id width.
REQ-002 SHALL have these ports: clk, in, 1, sole clock; all state on rising edge.
REQ-003 rst, in, 1, synchronous active-high reset.
REQ-004 copy_start_in, in, 1, start pulse from fork controller (l2_context_copy_start).
REQ-005 src_core_id_in / dst_core_id_in, in, CORE_ID_W each, master and speculative core; sampled with start.
REQ-006 abort_in, in, 1, squash of the target speculative task.
REQ-007 rf_rd_req_out, out, 1; rf_rd_core_out, out, CORE_ID_W; rf_rd_idx_out, out, $clog2(NUM_REGS): register-file read request.
REQ-008 rf_rd_ack_in, in, 1; rf_rd_data_in, in, DATA_W: read completes in the cycle where req and ack are both high; data valid that cycle.
REQ-009 rf_wr_req_out, out, 1; rf_wr_core_out, out, CORE_ID_W; rf_wr_idx_out, out, $clog2(NUM_REGS); rf_wr_data_out, out, DATA_W: write request.
REQ-010 rf_wr_ack_in, in, 1: write completes in the cycle where req and ack are both high.
REQ-011 copy_done_out, out, 1, one-cycle pulse on successful copy (l2_context_copy_done).
REQ-012 copy_error_out, out, 1, one-cycle pulse on rejected start; busy_out, out, 1, engine occupied.

Function
REQ-013 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-014 IDLE: copy_start_in high and src != dst -> latch ids, idx := first index, go RD; src == dst -> pulse copy_error_out next cycle, stay IDLE, no transfers.
REQ-015 RD: rf_rd_req_out=1, core=src, idx=current; on rd ack capture rf_rd_data_in into data register, go WR; else hold all outputs stable.
REQ-016 WR: rf_wr_req_out=1, core=dst, idx=current, data=captured; on wr ack: idx==NUM_REGS-1 -> DONE, else idx+1, go RD; else hold stable.
REQ-017 DONE: copy_done_out=1 for exactly one cycle, then IDLE.
REQ-018 busy_out SHALL be 1 in RD, WR, DONE; 0 in IDLE.
REQ-019 copy_start_in while not IDLE SHALL be ignored (no queuing, no error).
REQ-020 abort_in in RD/WR/DONE SHALL force IDLE next cycle; no copy_done_out that cycle or after; requests drop next cycle; abort wins over a same-cycle final wr ack.
REQ-021 abort_in in IDLE SHALL be ignored; abort and start in same IDLE cycle -> start ignored.
REQ-022 Never both rf_rd_req_out and rf_wr_req_out high in one cycle.
REQ-023 Zero-wait acks: done SHALL be high 2*COUNT+1 cycles after start cycle (start = cycle 0), COUNT = registers copied.
REQ-024 Index counter SHALL never exceed NUM_REGS-1; no wrap.

Reset
REQ-025 rst SHALL force IDLE, all outputs 0 (req, idx, core, data, done, error, busy), captured data 0, overriding any in-flight transfer next edge.

Configuration
REQ-026 Macro STU_CTX_SKIP_X0_EN: defined -> first index 1, COUNT=NUM_REGS-1, register 0 never read/written; undefined -> first index 0, COUNT=NUM_REGS.

Verification
REQ-027 Acks tied 1, NUM_REGS=32, src=0 dst=2, macro off -> 32 reads idx 0..31 core 0, 32 writes core 2 matching data, done at cycle 65, busy 1..65.
REQ-028 Same, STU_CTX_SKIP_X0_EN defined -> idx 1..31 only, done at cycle 63, no access to idx 0.
REQ-029 rd ack delayed 3 cycles on idx 5, wr ack delayed 2 on idx 7 -> req/idx/data held stable during waits; done at cycle 70.
REQ-030 abort_in at cycle 20 (acks tied 1) -> requests low at cycle 21, busy 0, copy_done_out never asserted; new start at 25 restarts at first index.
REQ-031 start with src=dst=1 -> copy_error_out pulse at cycle 1, no rf requests, busy stays 0.
REQ-032 rst asserted at cycle 10 during WR, start pulsed at cycle 10 -> all outputs 0 at cycle 11, IDLE, no done.
